// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared mult/div unit and the Hi/Lo register pair.
// Launches the selected unit, waits out its fixed latency, loads Hi/Lo and reports completion.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  input  logic divisor_zero,
  output logic mult_start,
  output logic div_start,
  output logic sel_mux_hi,
  output logic sel_mux_lo,
  output logic HiLo_load,
  output logic busy,
  output logic done,
  output logic div_zero
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    EXC   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_reg;

  // Control FSM; every output is registered and set on the edge entering its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op_reg     <= 1'b0;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      sel_mux_hi <= 1'b0;
      sel_mux_lo <= 1'b0;
      HiLo_load  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      HiLo_load  <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            // A zero divisor is trapped before the divider is ever started.
            if (op && divisor_zero) begin
              state    <= EXC;
              div_zero <= 1'b1;
            end else begin
              state      <= RUN;
              op_reg     <= op;
              cnt        <= op ? DIV_LOAD : MULT_LOAD;
              mult_start <= ~op;
              div_start  <= op;
              sel_mux_hi <= ~op;
              sel_mux_lo <= ~op;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state      <= WRITE;
            HiLo_load  <= 1'b1;
            sel_mux_hi <= ~op_reg;
            sel_mux_lo <= ~op_reg;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        EXC: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: per-cycle scoreboard against a latency model,
// a table of request scenarios, and hand-written reset/busy corner sequences.
module tb_muldiv_ctrl;

  localparam int MULT_N = 32;
  localparam int DIV_N  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, op = 1'b0, divisor_zero = 1'b0;
  logic mult_start, div_start, sel_mux_hi, sel_mux_lo, HiLo_load, busy, done, div_zero;

  muldiv_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .divisor_zero(divisor_zero),
    .mult_start(mult_start), .div_start(div_start), .sel_mux_hi(sel_mux_hi),
    .sel_mux_lo(sel_mux_lo), .HiLo_load(HiLo_load), .busy(busy), .done(done),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: cycles since acceptance, 0 when idle.
  int   m_t = 0;
  bit   m_exc = 1'b0;
  bit   m_op = 1'b0;
  int   m_n = 0;
  logic m_sel = 1'b0;
  logic [7:0] sb_q[$];

  // Observed event counters for the current scenario.
  int c_busy, c_start, c_load, c_done, c_dz;

  function automatic logic [7:0] outs();
    return {mult_start, div_start, sel_mux_hi, sel_mux_lo, HiLo_load, busy, done, div_zero};
  endfunction

  task automatic check_vec(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b expected=%b (ms,ds,shi,slo,load,busy,done,dz)",
               name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    m_exc = 1'b0;
    m_sel = 1'b0;
    sb_q.delete();
  endtask

  task automatic clear_counts();
    c_busy = 0; c_start = 0; c_load = 0; c_done = 0; c_dz = 0;
  endtask

  // Drive one cycle of inputs, push the expected outputs of the next cycle, then compare.
  task automatic step(input bit s, input bit o, input bit dz);
    logic [7:0] e;
    logic [7:0] a;
    start = s; op = o; divisor_zero = dz;
    if (m_t == 0) begin
      if (s) begin
        m_t   = 1;
        m_exc = o && dz;
        m_op  = o;
        m_n   = o ? DIV_N : MULT_N;
        if (!m_exc) m_sel = ~o;
      end
    end else begin
      m_t++;
      if (m_t > (m_exc ? 1 : m_n + 2)) m_t = 0;
    end
    e = {(m_t == 1 && !m_exc && !m_op), (m_t == 1 && !m_exc && m_op), m_sel, m_sel,
         (!m_exc && m_t == m_n + 1), (m_t != 0), (!m_exc && m_t == m_n + 2),
         (m_exc && m_t == 1)};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    a = outs();
    e = sb_q.pop_front();
    check_vec("cycle", a, e);
    c_busy  += int'(a[2]);
    c_start += int'(a[7]) + int'(a[6]);
    c_load  += int'(a[3]);
    c_done  += int'(a[1]);
    c_dz    += int'(a[0]);
  endtask

  typedef struct {
    string name;
    bit    op;
    bit    dz;
    int    exp_busy;
    int    exp_starts;
    int    exp_loads;
    int    exp_dones;
    int    exp_dzs;
    logic  exp_sel;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"mult",        1'b0, 1'b0, 34, 1, 1, 1, 0, 1'b1};
    vecs[1] = '{"div",         1'b1, 1'b0,  5, 1, 1, 1, 0, 1'b0};
    vecs[2] = '{"div_zero_a",  1'b1, 1'b1,  1, 0, 0, 0, 1, 1'b0};
    vecs[3] = '{"mult_dz_ign", 1'b0, 1'b1, 34, 1, 1, 1, 0, 1'b1};
    vecs[4] = '{"div_zero_b",  1'b1, 1'b1,  1, 0, 0, 0, 1, 1'b1};
    vecs[5] = '{"div_again",   1'b1, 1'b0,  5, 1, 1, 1, 0, 1'b0};

    // Reset held with start toggling: everything stays low.
    for (int i = 0; i < 4; i++) begin
      start = i[0]; op = 1'b0; divisor_zero = 1'b0;
      @(posedge clk);
      #1;
      check_vec("reset_hold", outs(), 8'h00);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);

    // Scenario table.
    foreach (vecs[i]) begin
      clear_counts();
      step(1'b1, vecs[i].op, vecs[i].dz);
      for (int k = 0; k < 40; k++) step(1'b0, 1'($urandom), 1'($urandom));
      check_int({vecs[i].name, "_busy"},   c_busy,  vecs[i].exp_busy);
      check_int({vecs[i].name, "_starts"}, c_start, vecs[i].exp_starts);
      check_int({vecs[i].name, "_loads"},  c_load,  vecs[i].exp_loads);
      check_int({vecs[i].name, "_dones"},  c_done,  vecs[i].exp_dones);
      check_int({vecs[i].name, "_dzs"},    c_dz,    vecs[i].exp_dzs);
      check_int({vecs[i].name, "_sel"},    int'(sel_mux_hi & sel_mux_lo), int'(vecs[i].exp_sel));
    end

    // Divide-by-zero immediately followed by a request in cycle 2.
    clear_counts();
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0);
    check_int("b2b_dzs", c_dz, 1);
    check_int("b2b_loads", c_load, 1);
    check_int("b2b_dones", c_done, 1);

    // Busy rejection: start pulses with op=1 in cycles 2, 17 and 34 of a mult.
    clear_counts();
    step(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 36; c++) step(c == 2 || c == 17 || c == 34, 1'b1, 1'b0);
    check_int("rej_starts", c_start, 1);
    check_int("rej_loads", c_load, 1);
    check_int("rej_dones", c_done, 1);
    check_int("rej_sel", int'(sel_mux_hi & sel_mux_lo), 1);

    // Asynchronous reset in cycle 10 of a mult.
    step(1'b1, 1'b0, 1'b0);
    for (int c = 1; c < 10; c++) step(1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_vec("async_reset", outs(), 8'h00);
    for (int i = 0; i < 2; i++) begin
      start = ~start;
      @(posedge clk);
      #1;
      check_vec("reset_mid_hold", outs(), 8'h00);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    clear_counts();
    for (int k = 0; k < 30; k++) step(1'b0, 1'b0, 1'b0);
    check_int("post_reset_loads", c_load, 0);
    check_int("post_reset_dones", c_done, 0);
    clear_counts();
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0);
    check_int("fresh_div_loads", c_load, 1);
    check_int("fresh_div_dones", c_done, 1);
    check_int("fresh_div_sel", int'(sel_mux_hi | sel_mux_lo), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
